sorted_record_drain: RTL and testbench



---
 rtl/sorted_record_drain.sv | 106 ++++++++++
 tb/tb_sorted_record_drain.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sorted_record_drain.sv
// Pops one record at a time from the RAM manager and streams it out MSB byte first,
// flagging out-of-order keys and counting delivered records.
module sorted_record_drain #(
  parameter int RECORD_W = 48,
  parameter int KEY_MSB  = 47,
  parameter int KEY_LSB  = 16,
  parameter int POP_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                drain_en,
  input  logic                empty,
  input  logic                min_valid,
  input  logic [RECORD_W-1:0] min_record,
  output logic                pop_from_ram,
  output logic [7:0]          out_byte,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                order_err,
  output logic [15:0]         rec_count,
  output logic                busy,
  input  logic                cnt_load,
  input  logic [15:0]         cnt_load_val,
  output logic [1:0]          fsm_state
);
  localparam int NBYTES = RECORD_W / 8;
  localparam int KEY_W  = KEY_MSB - KEY_LSB + 1;
  localparam int BC_W   = $clog2(NBYTES + 1);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, SEND = 2'd2} state_t;

  // Stream handshake: a byte transfers on a rising edge where out_valid && out_ready;
  // out_byte/out_last never change while out_valid is high and out_ready is low.
  state_t              state;
  logic [3:0]          wait_cnt;
  logic [RECORD_W-1:0] shreg;
  logic [BC_W-1:0]     byte_cnt;
  logic [KEY_W-1:0]    prev_key;
  logic [KEY_W-1:0]    cap_key;
  logic                first_seen;

  assign cap_key   = min_record[KEY_MSB:KEY_LSB];
  assign out_byte  = shreg[RECORD_W-1 -: 8];
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      shreg        <= '0;
      byte_cnt     <= '0;
      prev_key     <= '0;
      first_seen   <= 1'b0;
      pop_from_ram <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      order_err    <= 1'b0;
      rec_count    <= '0;
    end else begin
      pop_from_ram <= 1'b0;
      if (cnt_load) rec_count <= cnt_load_val;
      case (state)
        IDLE: begin
          if (drain_en && !empty) begin
            pop_from_ram <= 1'b1;
            wait_cnt     <= 4'(POP_LAT);
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0 && min_valid) begin
            shreg      <= min_record;
            byte_cnt   <= '0;
            out_valid  <= 1'b1;
            out_last   <= 1'(NBYTES == 1);
            state      <= SEND;
            // equal keys are legal; only a strict decrease is an ordering fault
            if (first_seen && (cap_key < prev_key)) order_err <= 1'b1;
            prev_key   <= cap_key;
            first_seen <= 1'b1;
          end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        SEND: begin
          if (out_ready) begin
            shreg <= shreg << 8;
            if (byte_cnt == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              rec_count <= rec_count + 16'd1;
              state     <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
              out_last <= (byte_cnt == LAST_IDX - BC_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sorted_record_drain.sv
// Randomized bench for sorted_record_drain: a small RAM-manager model feeds records,
// a byte queue and key history predict the stream, ordering flag and record count.
module tb_sorted_record_drain;
  logic        clk = 1'b0;
  logic        rst_b;
  logic        drain_en, empty, min_valid, out_ready, cnt_load;
  logic [47:0] min_record;
  logic [15:0] cnt_load_val;
  logic        pop_from_ram, out_valid, out_last, order_err, busy;
  logic [7:0]  out_byte;
  logic [15:0] rec_count;
  logic [1:0]  fsm_state;

  int          n_checks = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] key_hist[$];
  logic [15:0] model_count = '0;

  sorted_record_drain dut (
    .clk(clk), .rst_b(rst_b), .drain_en(drain_en), .empty(empty),
    .min_valid(min_valid), .min_record(min_record), .pop_from_ram(pop_from_ram),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .order_err(order_err), .rec_count(rec_count), .busy(busy),
    .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err();
    for (int i = 1; i < key_hist.size(); i++)
      if (key_hist[i] < key_hist[i-1]) return 1'b1;
    return 1'b0;
  endfunction

  // mode 0: ready always high, 1: ready pattern 1,0,0,..., 2: random ready
  // vdelay: min_valid held low that many cycles after the pop (0 = valid already)
  // stop_at: >=0 abandons the record after that many bytes (caller resets)
  task automatic run_record(input logic [47:0] rec, input int mode, input int vdelay,
                            input int stop_at);
    int k, got, pat, lat, extra, lat_exp;
    logic stalled, hl, last_exp;
    logic [7:0] hb, b_exp;
    min_record = rec; min_valid = 1'b1; empty = 1'b0; drain_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(rec[47-8*i -: 8]);
    k = 0;
    while (!pop_from_ram && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("pop_wait", k, 1);
    if (!pop_from_ram) begin
      exp_q.delete();
      return;
    end
    empty = 1'b1;
    min_valid = (vdelay == 0);
    key_hist.push_back(rec[47:16]);
    k = 0; got = 0; pat = 0; lat = -1; extra = 0; stalled = 1'b0; hb = '0; hl = 1'b0;
    while (got < 6 && k < 300) begin
      @(negedge clk);
      k++;
      if (k == vdelay) min_valid = 1'b1;
      if (pop_from_ram) extra++;
      if (out_valid && lat < 0) lat = k;
      if (stalled) begin
        check_eq("hold_byte", out_byte, hb);
        check_eq("hold_last", out_last, hl);
      end
      if (out_valid) begin
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = (pat % 3 == 0);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        pat++;
        if (out_ready) begin
          b_exp = exp_q.pop_front();
          last_exp = (exp_q.size() == 0);
          check_eq("byte", out_byte, b_exp);
          check_eq("last", out_last, last_exp);
          got++;
          stalled = 1'b0;
          if (got == stop_at) break;
        end else begin
          stalled = 1'b1; hb = out_byte; hl = out_last;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (got == stop_at) begin
      exp_q.delete();
      return;
    end
    check_eq("bytes_done", got, 6);
    lat_exp = (vdelay + 1 > 3) ? vdelay + 1 : 3;
    check_eq("latency", lat, lat_exp);
    @(negedge clk);
    out_ready = 1'b0;
    if (pop_from_ram) extra++;
    model_count = model_count + 16'd1;
    check_eq("rec_count", rec_count, model_count);
    check_eq("valid_drop", out_valid, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("order_err", order_err, model_err());
    check_eq("single_pop", extra, 0);
    exp_q.delete();
  endtask

  initial begin
    int pops, busy_seen, valid_seen, vd, md;
    logic [31:0] key;
    logic [15:0] val;
    rst_b = 1'b0; drain_en = 1'b0; empty = 1'b1; min_valid = 1'b0; min_record = '0;
    out_ready = 1'b0; cnt_load = 1'b0; cnt_load_val = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_pop", pop_from_ram, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_byte", out_byte, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_err", order_err, 0);
    check_eq("rst_count", rec_count, 0);
    check_eq("rst_busy", busy, 0);

    rst_b = 1'b1; drain_en = 1'b1; empty = 1'b1;
    pops = 0; busy_seen = 0; valid_seen = 0;
    repeat (20) begin
      @(negedge clk);
      pops += int'(pop_from_ram); busy_seen += int'(busy); valid_seen += int'(out_valid);
    end
    check_eq("empty_pops", pops, 0);
    check_eq("empty_busy", busy_seen, 0);
    check_eq("empty_valid", valid_seen, 0);

    run_record(48'h00000001_ABCD, 0, 0, -1);
    run_record(48'h00000001_ABCD, 1, 0, -1);
    run_record(48'h00000001_ABCD, 0, 10, -1);

    key = 32'd1;
    for (int i = 0; i < 12; i++) begin
      key = key + 32'($urandom_range(0, 2));
      val = 16'($urandom);
      md = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0: vd = 0;
        1: vd = 1;
        2: vd = 5;
        default: vd = 10;
      endcase
      run_record({key, val}, md, vd, -1);
    end

    run_record(48'h00000009_5555, 0, 0, 3);
    @(negedge clk);
    rst_b = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_count", rec_count, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_last", out_last, 0);
    model_count = '0;
    key_hist.delete();
    @(negedge clk);
    rst_b = 1'b1;

    run_record(48'h00000005_1111, 2, 0, -1);
    run_record(48'h00000005_2222, 0, 0, -1);
    run_record(48'h00000003_3333, 1, 0, -1);
    run_record(48'h00000007_4444, 2, 2, -1);

    @(negedge clk);
    cnt_load = 1'b1; cnt_load_val = 16'hFFFF;
    @(negedge clk);
    cnt_load = 1'b0;
    check_eq("preload", rec_count, 16'hFFFF);
    model_count = 16'hFFFF;
    run_record(48'h00000014_0F0F, 0, 0, -1);
    check_eq("wrap_zero", rec_count, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
